// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle, result written straight to the register file.
module div_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int ITER   = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   dividend,
    input  logic [XLEN-1:0]   divisor,
    input  logic [ADDR_W-1:0] rd,
    input  logic              flush,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [XLEN-1:0]   wr_data
);

    localparam int CW = $clog2(ITER + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvs_q;
    logic              is_rem_q;
    logic              qneg_q;
    logic              rneg_q;
    logic [ADDR_W-1:0] rd_q;

    // op[0]=1 selects the unsigned variants, op[1]=1 selects remainder
    logic            signed_op, is_rem;
    logic            dvd_neg, dvs_neg;
    logic [XLEN-1:0] dvd_abs, dvs_abs;
    logic            div_zero, ovf, special;
    logic [XLEN-1:0] spec_res;
    logic            accept;

    assign signed_op = ~op[0];
    assign is_rem    = op[1];
    assign dvd_neg   = signed_op & dividend[XLEN-1];
    assign dvs_neg   = signed_op & divisor[XLEN-1];
    assign dvd_abs   = dvd_neg ? -dividend : dividend;
    assign dvs_abs   = dvs_neg ? -divisor : divisor;
    assign div_zero  = (divisor == '0);
    assign ovf       = signed_op & (dividend == MIN_NEG) & (divisor == '1);
    assign special   = div_zero | ovf;
    assign accept    = (state == IDLE) & start_valid & ~flush;

    // divide-by-zero and signed overflow have fixed architectural results
    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = is_rem ? dividend : '1;
        else
            spec_res = is_rem ? '0 : MIN_NEG;
    end

    // one restoring step: shift in the next dividend bit, subtract if it fits
    logic [XLEN:0]   shift, rem_n;
    logic [XLEN-1:0] quo_n;
    logic            ge;
    logic [XLEN-1:0] q_res, r_res, calc_res;
    logic            last;

    assign shift    = (rem_q << 1) | {{XLEN{1'b0}}, quo_q[XLEN-1]};
    assign ge       = (shift >= {1'b0, dvs_q});
    assign rem_n    = ge ? (shift - {1'b0, dvs_q}) : shift;
    assign quo_n    = {quo_q[XLEN-2:0], ge};
    assign q_res    = qneg_q ? -quo_n : quo_n;
    assign r_res    = rneg_q ? -rem_n[XLEN-1:0] : rem_n[XLEN-1:0];
    assign calc_res = is_rem_q ? r_res : q_res;
    assign last     = (cnt == CW'(ITER - 1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state and handshake/write-enable outputs
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        busy        = 1'b1;
        wr_en       = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (accept)
                    state_nxt = special ? DONE : CALC;
            end
            CALC: begin
                if (flush)
                    state_nxt = IDLE;
                else if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                wr_en     = ~flush & (rd_q != '0);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand latch, iteration datapath and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            rd_q     <= '0;
            wr_reg   <= '0;
            wr_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem_q <= is_rem;
                        qneg_q   <= dvd_neg ^ dvs_neg;
                        rneg_q   <= dvd_neg;
                        rd_q     <= rd;
                        dvs_q    <= dvs_abs;
                        quo_q    <= dvd_abs;
                        rem_q    <= '0;
                        cnt      <= '0;
                        if (special) begin
                            wr_reg  <= rd;
                            wr_data <= spec_res;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt   <= cnt + CW'(1);
                    if (last && !flush) begin
                        wr_reg  <= rd_q;
                        wr_data <= calc_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
